gshare_btb_predictor: RTL and testbench

Fetch-stage branch predictor that produces the branch_predict_type bundle consumed by the execute-stage branch/jump unit.
- Holds a 2-bit-counter PHT indexed gshare-style, a direct-mapped BTB, and the speculative global history register (GHSR).
- Trains PHT/BTB from resolved branch/jump results and repairs GHSR on a flush using the restore value produced in execute.
- Also keeps branch/mispredict performance counters.

---
 rtl/gshare_btb_predictor_pkg.sv | 17 +
 rtl/gshare_btb_predictor_btb_table.sv | 52 +++++
 rtl/gshare_btb_predictor.sv | 111 +++++++++++
 tb/tb_gshare_btb_predictor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_btb_predictor_pkg.sv
// Shared types and constants for the gshare/BTB fetch predictor.
package gshare_btb_predictor_pkg;

    localparam int GSHARE_GHSR_WIDTH     = 8;
    localparam int BTB_IDX_WIDTH_DEFAULT = 4;

    // Every PHT counter starts weakly not-taken.
    localparam logic [1:0] PHT_RESET = 2'b01;

    typedef struct packed {
        logic                         btb_hit;
        logic                         taken;
        logic [31:0]                  btb_addr;
        logic [GSHARE_GHSR_WIDTH-1:0] current_GHSR;
    } branch_predict_type;

endpackage

// File: rtl/gshare_btb_predictor_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup, one write port.
// Addresses are word addresses (pc[31:2]); the tag is the part above the index.
module gshare_btb_predictor_btb_table #(
    parameter int IDX_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] lookup_word,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_target
);

    localparam int ENTRIES = 1 << IDX_WIDTH;
    localparam int TAG_W   = 30 - IDX_WIDTH;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    logic [IDX_WIDTH-1:0] rd_idx;
    logic [IDX_WIDTH-1:0] wr_idx;

    assign rd_idx = lookup_word[IDX_WIDTH-1:0];
    assign wr_idx = wr_word[IDX_WIDTH-1:0];

    // Valid bits are the only state that needs reset; a cleared entry never hits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload, overwritten on every taken resolution.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_word[29:IDX_WIDTH];
            target_mem[wr_idx] <= wr_target;
        end
    end

    // Lookup reads the pre-write contents during a same-cycle write.
    always_comb begin
        hit    = valid[rd_idx] && (tag_mem[rd_idx] == lookup_word[29:IDX_WIDTH]);
        target = hit ? target_mem[rd_idx] : 32'h0;
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage gshare direction predictor with direct-mapped BTB, speculative
// global history with flush repair, and branch/mispredict counters.
module gshare_btb_predictor
    import gshare_btb_predictor_pkg::*;
#(
    parameter int BTB_IDX_WIDTH = BTB_IDX_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_pc,
    output branch_predict_type           branch_predict,
    output logic [31:0]                  predict_next_pc,
    input  logic                         ex_valid,
    input  logic [31:0]                  ex_pc,
    input  logic                         ex_taken,
    input  logic [31:0]                  ex_target,
    input  logic [GSHARE_GHSR_WIDTH-1:0] ex_GHSR,
    input  logic                         flush,
    input  logic [GSHARE_GHSR_WIDTH-1:0] GHSR_restore,
    input  logic                         update_GHSR,
    output logic [31:0]                  branch_count,
    output logic [31:0]                  mispredict_count
);

    localparam int GHSR_WIDTH  = GSHARE_GHSR_WIDTH;
    localparam int PHT_ENTRIES = 1 << GHSR_WIDTH;

    logic [GHSR_WIDTH-1:0] ghsr;
    logic [1:0]            pht [PHT_ENTRIES];

    logic [GHSR_WIDTH-1:0] rd_idx;
    logic [GHSR_WIDTH-1:0] wr_idx;
    logic                  btb_hit;
    logic [31:0]           btb_target;
    logic                  pred_taken;
    logic [1:0]            wr_ctr;

    // ex_pc is word aligned; its byte offset carries no information here.
    logic [1:0] unused_ex_pc_lsb;
    assign unused_ex_pc_lsb = ex_pc[1:0];

    assign rd_idx = fetch_pc[GHSR_WIDTH+1:2] ^ ghsr;
    assign wr_idx = ex_pc[GHSR_WIDTH+1:2] ^ ex_GHSR;
    assign wr_ctr = pht[wr_idx];

    gshare_btb_predictor_btb_table #(
        .IDX_WIDTH (BTB_IDX_WIDTH)
    ) u_btb (
        .clk         (clk),
        .reset_n     (reset_n),
        .lookup_word (fetch_pc[31:2]),
        .hit         (btb_hit),
        .target      (btb_target),
        .wr_en       (ex_valid && ex_taken),
        .wr_word     (ex_pc[31:2]),
        .wr_target   (ex_target)
    );

    // Zero-latency prediction; a direction without a known target is never taken.
    always_comb begin
        pred_taken                  = btb_hit && pht[rd_idx][1];
        branch_predict.btb_hit      = btb_hit;
        branch_predict.taken        = pred_taken;
        branch_predict.btb_addr     = btb_target;
        branch_predict.current_GHSR = ghsr;
        predict_next_pc             = pred_taken ? btb_target : (fetch_pc + 32'd4);
    end

    // Flush repair wins over the speculative shift issued by fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghsr <= '0;
        end else if (flush) begin
            ghsr <= update_GHSR ? {GHSR_restore[GHSR_WIDTH-2:0], ex_taken} : GHSR_restore;
        end else if (fetch_valid && btb_hit) begin
            ghsr <= {ghsr[GHSR_WIDTH-2:0], pred_taken};
        end
    end

    // Saturating 2-bit counter training from resolved branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= PHT_RESET;
            end
        end else if (ex_valid) begin
            if (ex_taken && (wr_ctr != 2'b11)) begin
                pht[wr_idx] <= wr_ctr + 2'b01;
            end else if (!ex_taken && (wr_ctr != 2'b00)) begin
                pht[wr_idx] <= wr_ctr - 2'b01;
            end
        end
    end

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid) begin
                branch_count <= branch_count + 32'd1;
            end
            if (flush) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed self-checking bench for gshare_btb_predictor.
module tb_gshare_btb_predictor;
    import gshare_btb_predictor_pkg::*;

    logic               clk;
    logic               reset_n;
    logic               fetch_valid;
    logic [31:0]        fetch_pc;
    branch_predict_type branch_predict;
    logic [31:0]        predict_next_pc;
    logic               ex_valid;
    logic [31:0]        ex_pc;
    logic               ex_taken;
    logic [31:0]        ex_target;
    logic [7:0]         ex_GHSR;
    logic               flush;
    logic [7:0]         GHSR_restore;
    logic               update_GHSR;
    logic [31:0]        branch_count;
    logic [31:0]        mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ex_cnt   = 0;
    int fl_cnt   = 0;

    gshare_btb_predictor dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .branch_predict   (branch_predict),
        .predict_next_pc  (predict_next_pc),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_GHSR          (ex_GHSR),
        .flush            (flush),
        .GHSR_restore     (GHSR_restore),
        .update_GHSR      (update_GHSR),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle resolved-branch pulse, launched on a falling edge.
    task automatic do_ex(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [7:0] gh);
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_GHSR = gh;
        @(negedge clk);
        ex_valid = 1'b0; ex_taken = 1'b0;
        ex_cnt++;
    endtask

    // One-cycle flush pulse, optionally with a concurrent fetch of fetch_pc.
    task automatic do_flush(input logic [7:0] rst_val, input logic upd,
                            input logic tk, input logic fv);
        @(negedge clk);
        flush = 1'b1; GHSR_restore = rst_val; update_GHSR = upd; ex_taken = tk;
        fetch_valid = fv;
        @(negedge clk);
        flush = 1'b0; update_GHSR = 1'b0; ex_taken = 1'b0; fetch_valid = 1'b0;
        fl_cnt++;
    endtask

    task automatic test_reset();
        fetch_pc = 32'h100;
        #2;
        n_checks++;
        if (branch_predict !== '{btb_hit: 1'b0, taken: 1'b0, btb_addr: 32'h0, current_GHSR: 8'h0}) begin
            n_fail++; $display("FAIL reset_bundle: got %h want 0", branch_predict);
        end
        n_checks++;
        if (predict_next_pc !== 32'h104) begin
            n_fail++; $display("FAIL reset_npc: got %h want 00000104", predict_next_pc);
        end
        n_checks++;
        if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_counts: got %h/%h want 0/0", branch_count, mispredict_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0 || predict_next_pc !== 32'h104) begin
            n_fail++; $display("FAIL post_reset_miss: got hit=%b npc=%h want 0/00000104",
                               branch_predict.btb_hit, predict_next_pc);
        end
    endtask

    task automatic test_train_taken();
        fetch_pc = 32'h100;
        do_ex(32'h100, 1'b1, 32'h40, 8'h00);
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1 || branch_predict.taken !== 1'b1) begin
            n_fail++; $display("FAIL train_first: got hit=%b taken=%b want 1/1",
                               branch_predict.btb_hit, branch_predict.taken);
        end
        do_ex(32'h100, 1'b1, 32'h40, 8'h00);
        n_checks++;
        if (branch_predict.btb_addr !== 32'h40 || predict_next_pc !== 32'h40 ||
            branch_predict.taken !== 1'b1) begin
            n_fail++; $display("FAIL train_second: got addr=%h npc=%h taken=%b want 40/40/1",
                               branch_predict.btb_addr, predict_next_pc, branch_predict.taken);
        end
    endtask

    task automatic test_spec_shift();
        @(negedge clk);
        fetch_pc = 32'h100; fetch_valid = 1'b1;
        #2;
        n_checks++;
        if (branch_predict.current_GHSR !== 8'h00) begin
            n_fail++; $display("FAIL shift_pre_ghsr: got %h want 00", branch_predict.current_GHSR);
        end
        @(negedge clk);
        fetch_valid = 1'b0;
        #2;
        n_checks++;
        if (branch_predict.current_GHSR !== 8'h01) begin
            n_fail++; $display("FAIL shift_ghsr: got %h want 01", branch_predict.current_GHSR);
        end
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1 || branch_predict.taken !== 1'b0 ||
            predict_next_pc !== 32'h104) begin
            n_fail++; $display("FAIL shift_predict: got hit=%b taken=%b npc=%h want 1/0/00000104",
                               branch_predict.btb_hit, branch_predict.taken, predict_next_pc);
        end
    endtask

    task automatic test_flush_priority();
        fetch_pc = 32'h100;
        do_flush(8'hA5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (branch_predict.current_GHSR !== 8'hA5 || branch_predict.btb_hit !== 1'b1) begin
            n_fail++; $display("FAIL flush_restore: got ghsr=%h hit=%b want a5/1",
                               branch_predict.current_GHSR, branch_predict.btb_hit);
        end
        do_flush(8'h3C, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (branch_predict.current_GHSR !== 8'h78) begin
            n_fail++; $display("FAIL flush_wins: got %h want 78", branch_predict.current_GHSR);
        end
        do_flush(8'h3C, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (branch_predict.current_GHSR !== 8'h79) begin
            n_fail++; $display("FAIL flush_update_taken: got %h want 79", branch_predict.current_GHSR);
        end
        n_checks++;
        if (mispredict_count !== 32'd3) begin
            n_fail++; $display("FAIL mispredict_count: got %0d want 3", mispredict_count);
        end
        do_flush(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        fetch_pc = 32'h100;
        // third increment of PHT[0x40] must stay at 3
        do_ex(32'h100, 1'b1, 32'h40, 8'h00);
        n_checks++;
        if (branch_predict.taken !== 1'b1) begin
            n_fail++; $display("FAIL sat_high: got taken=%b want 1", branch_predict.taken);
        end
        do_ex(32'h100, 1'b0, 32'h0, 8'h00);
        n_checks++;
        if (branch_predict.taken !== 1'b1 || branch_predict.btb_addr !== 32'h40) begin
            n_fail++; $display("FAIL sat_high_dec: got taken=%b addr=%h want 1/40",
                               branch_predict.taken, branch_predict.btb_addr);
        end
        // BTB entry for 0x204 trained via a different PHT index (0x81^0x10)
        do_ex(32'h204, 1'b1, 32'h80, 8'h10);
        fetch_pc = 32'h204;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1 || branch_predict.taken !== 1'b0) begin
            n_fail++; $display("FAIL sat_low_start: got hit=%b taken=%b want 1/0",
                               branch_predict.btb_hit, branch_predict.taken);
        end
        for (int i = 0; i < 6; i++) do_ex(32'h204, 1'b0, 32'h0, 8'h00);
        n_checks++;
        if (branch_predict.taken !== 1'b0 || predict_next_pc !== 32'h208) begin
            n_fail++; $display("FAIL sat_low_hold: got taken=%b npc=%h want 0/00000208",
                               branch_predict.taken, predict_next_pc);
        end
        do_ex(32'h204, 1'b1, 32'h80, 8'h00);
        n_checks++;
        if (branch_predict.taken !== 1'b0) begin
            n_fail++; $display("FAIL sat_low_inc1: got taken=%b want 0", branch_predict.taken);
        end
        do_ex(32'h204, 1'b1, 32'h80, 8'h00);
        n_checks++;
        if (branch_predict.taken !== 1'b1 || predict_next_pc !== 32'h80) begin
            n_fail++; $display("FAIL sat_low_inc2: got taken=%b npc=%h want 1/00000080",
                               branch_predict.taken, predict_next_pc);
        end
    endtask

    task automatic test_same_cycle_and_alias();
        @(negedge clk);
        fetch_pc = 32'h308;
        ex_valid = 1'b1; ex_pc = 32'h308; ex_taken = 1'b1; ex_target = 32'h1000; ex_GHSR = 8'h00;
        #2;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0 || predict_next_pc !== 32'h30C) begin
            n_fail++; $display("FAIL same_cycle_old: got hit=%b npc=%h want 0/0000030c",
                               branch_predict.btb_hit, predict_next_pc);
        end
        @(negedge clk);
        ex_valid = 1'b0; ex_taken = 1'b0;
        ex_cnt++;
        #2;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1 || predict_next_pc !== 32'h1000) begin
            n_fail++; $display("FAIL same_cycle_new: got hit=%b npc=%h want 1/00001000",
                               branch_predict.btb_hit, predict_next_pc);
        end
        // 0x148 aliases BTB entry 2 with a different tag
        do_ex(32'h148, 1'b1, 32'h2000, 8'h00);
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0) begin
            n_fail++; $display("FAIL alias_evict: got hit=%b want 0", branch_predict.btb_hit);
        end
        fetch_pc = 32'h148;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1 || predict_next_pc !== 32'h2000) begin
            n_fail++; $display("FAIL alias_new: got hit=%b npc=%h want 1/00002000",
                               branch_predict.btb_hit, predict_next_pc);
        end
        do_ex(32'h30C, 1'b0, 32'h3000, 8'h00);
        fetch_pc = 32'h30C;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0) begin
            n_fail++; $display("FAIL not_taken_no_btb: got hit=%b want 0", branch_predict.btb_hit);
        end
        n_checks++;
        if (branch_count !== ex_cnt || mispredict_count !== fl_cnt) begin
            n_fail++; $display("FAIL counts: got %0d/%0d want %0d/%0d",
                               branch_count, mispredict_count, ex_cnt, fl_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        fetch_pc = 32'h100;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got hit=%b want 1", branch_predict.btb_hit);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0 || branch_predict.btb_addr !== 32'h0 ||
            branch_count !== 32'h0) begin
            n_fail++; $display("FAIL areset_now: got hit=%b addr=%h bc=%0d want 0/0/0",
                               branch_predict.btb_hit, branch_predict.btb_addr, branch_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fetch_pc = 32'h204;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0 || branch_predict.current_GHSR !== 8'h00 ||
            mispredict_count !== 32'h0) begin
            n_fail++; $display("FAIL areset_after: got hit=%b ghsr=%h mc=%0d want 0/00/0",
                               branch_predict.btb_hit, branch_predict.current_GHSR, mispredict_count);
        end
        fetch_pc = 32'h148;
        #1;
        n_checks++;
        if (branch_predict.btb_hit !== 1'b0 || predict_next_pc !== 32'h14C) begin
            n_fail++; $display("FAIL areset_alias: got hit=%b npc=%h want 0/0000014c",
                               branch_predict.btb_hit, predict_next_pc);
        end
    endtask

    initial begin
        reset_n = 1'b0; fetch_valid = 1'b0; fetch_pc = 32'h0;
        ex_valid = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0; ex_target = 32'h0; ex_GHSR = 8'h0;
        flush = 1'b0; GHSR_restore = 8'h0; update_GHSR = 1'b0;
        test_reset();
        test_train_taken();
        test_spec_shift();
        test_flush_priority();
        test_saturation();
        test_same_cycle_and_alias();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
